// File: rtl/osc_pkg.sv
// Shared definitions for the oscillator channel: waveform codes, FSM states and
// the raw-waveform helper.
package osc_pkg;

  localparam logic [1:0] WAVE_SAW = 2'd0;
  localparam logic [1:0] WAVE_SQR = 2'd1;
  localparam logic [1:0] WAVE_TRI = 2'd2;
  localparam logic [1:0] WAVE_OFF = 2'd3;

  localparam int unsigned OSC_LATENCY = 18;
  localparam int unsigned MUL_ITER    = 16;

  typedef enum logic [1:0] {
    StIdle,
    StWave,
    StMul,
    StOut
  } osc_state_e;

  // Raw signed 16-bit sample from the top 16 phase bits; arithmetic wraps mod 2^16.
  function automatic logic [15:0] wave_raw(input logic [1:0] sel, input logic [15:0] u);
    logic [16:0] two_u;
    logic [15:0] raw;
    two_u = {u, 1'b0};
    unique case (sel)
      WAVE_SAW: raw = {~u[15], u[14:0]};
      WAVE_SQR: raw = u[15] ? 16'h8000 : 16'h7fff;
      WAVE_TRI: raw = u[15] ? 16'(17'd98303 - two_u) : 16'(two_u - 17'd32768);
      default:  raw = '0;
    endcase
    return raw;
  endfunction

endpackage

// File: rtl/seq_mult_su.sv
// Sequential signed(W) x unsigned(W) shift-add multiplier, one multiplier bit per cycle.
module seq_mult_su
  import osc_pkg::*;
#(
  parameter int unsigned W = MUL_ITER
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           done,
  output logic [2*W-1:0] product
);

  localparam int unsigned CntW = $clog2(W);

  logic [2*W-1:0] acc_q;
  logic [2*W-1:0] a_sh_q;
  logic [W-1:0]   b_q;
  logic [CntW-1:0] cnt_q;
  logic           run_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q  <= '0;
      a_sh_q <= '0;
      b_q    <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
    end else if (start) begin
      acc_q  <= '0;
      a_sh_q <= {{W{a[W-1]}}, a};
      b_q    <= b;
      cnt_q  <= '0;
      run_q  <= 1'b1;
    end else if (run_q) begin
      // Sign-extended multiplicand: the sum is exact modulo 2^(2W), which the product fits.
      if (b_q[0]) begin
        acc_q <= acc_q + a_sh_q;
      end
      a_sh_q <= a_sh_q << 1;
      b_q    <= b_q >> 1;
      cnt_q  <= cnt_q + 1'b1;
      if (cnt_q == CntW'(W - 1)) begin
        run_q <= 1'b0;
      end
    end
  end

  // High during the final iteration; product is complete from the next cycle on.
  assign done    = run_q && (cnt_q == CntW'(W - 1));
  assign product = acc_q;

endmodule

// File: rtl/osc_channel.sv
// One audio channel: phase accumulator, waveform shaping and amplitude scaling,
// producing one signed sample per accepted sample-rate trigger.
module osc_channel
  import osc_pkg::*;
#(
  parameter int unsigned PHASE_W = 24,
  parameter int unsigned DATA_W  = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               smpl_rate_trig,
  input  logic [PHASE_W-1:0] freq_inc,
  input  logic [1:0]         wave_sel,
  input  logic [DATA_W-1:0]  amplitude,
  output logic [DATA_W-1:0]  sample_out,
  output logic               sample_valid,
  output logic               busy,
  output logic               trig_overrun
);

  osc_state_e          state_q, state_d;
  logic [PHASE_W-1:0]  phase_q;
  logic [1:0]          wave_q;
  logic [DATA_W-1:0]   amp_q;
  logic                accept;
  logic                overrun_set;
  logic                mult_start;
  logic                mult_done;
  logic [DATA_W-1:0]   raw;
  logic [2*DATA_W-1:0] product;
  logic                unused_prod_lsb;

  assign raw             = wave_raw(wave_q, phase_q[PHASE_W-1 -: 16]);
  assign unused_prod_lsb = ^product[DATA_W-1:0];

  seq_mult_su #(
    .W(DATA_W)
  ) u_mult (
    .clk    (clk),
    .reset  (reset),
    .start  (mult_start),
    .a      (raw),
    .b      (amp_q),
    .done   (mult_done),
    .product(product)
  );

  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    overrun_set = 1'b0;
    mult_start  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (smpl_rate_trig) begin
          accept  = 1'b1;
          state_d = StWave;
        end
      end
      StWave: begin
        mult_start  = 1'b1;
        overrun_set = smpl_rate_trig;
        state_d     = StMul;
      end
      StMul: begin
        overrun_set = smpl_rate_trig;
        if (mult_done) begin
          state_d = StOut;
        end
      end
      StOut: begin
        // IDLE is re-entered on this edge, so a coincident trigger starts the next sample.
        state_d = StIdle;
        if (smpl_rate_trig) begin
          accept  = 1'b1;
          state_d = StWave;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      phase_q      <= '0;
      wave_q       <= WAVE_SAW;
      amp_q        <= '0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      trig_overrun <= 1'b0;
    end else begin
      state_q      <= state_d;
      sample_valid <= (state_q == StOut);
      if (accept) begin
        phase_q <= phase_q + freq_inc;
        wave_q  <= wave_sel;
        amp_q   <= amplitude;
      end
      if (state_q == StOut) begin
        sample_out <= product[2*DATA_W-1 -: DATA_W];
      end
      if (overrun_set) begin
        trig_overrun <= 1'b1;
      end
    end
  end

  assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_osc_channel.sv
// Scoreboard bench for osc_channel: a driver pushes model expectations, a monitor
// pops and compares on every sample_valid strobe.
module tb_osc_channel;

  typedef struct {
    int     val;
    longint due;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        trig;
  logic [23:0] freq;
  logic [1:0]  wsel;
  logic [15:0] amp;
  logic [15:0] sample_out;
  logic        sample_valid;
  logic        busy;
  logic        trig_overrun;

  int          total = 0;
  int          bad = 0;
  longint      cyc = 0;
  exp_t        sb[$];
  int unsigned model_ph = 0;
  longint      next_free = 0;
  logic        model_ovr = 1'b0;
  int          held = 0;

  osc_channel #(
    .PHASE_W(24),
    .DATA_W (16)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .smpl_rate_trig(trig),
    .freq_inc      (freq),
    .wave_sel      (wsel),
    .amplitude     (amp),
    .sample_out    (sample_out),
    .sample_valid  (sample_valid),
    .busy          (busy),
    .trig_overrun  (trig_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference: sample = floor(raw * amplitude / 65536) from the top 16 phase bits.
  function automatic int model_sample(input int unsigned ph, input int w, input int a);
    longint u;
    longint raw;
    u = longint'(ph >> 8);
    case (w)
      0:       raw = u - 32768;
      1:       raw = (u < 32768) ? 32767 : -32768;
      2:       raw = (u < 32768) ? 2 * u - 32768 : 98303 - 2 * u;
      default: raw = 0;
    endcase
    return int'((raw * longint'(a)) >>> 16);
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic issue_trig(input logic [23:0] f, input logic [1:0] w, input logic [15:0] a);
    exp_t e;
    @(negedge clk);
    freq = f;
    wsel = w;
    amp  = a;
    trig = 1'b1;
    if (cyc + 1 >= next_free) begin
      model_ph  = (model_ph + 32'(f)) & 32'h00ff_ffff;
      e.val     = model_sample(model_ph, int'(w), int'(a));
      e.due     = cyc + 1 + 18;
      next_free = cyc + 1 + 18;
      sb.push_back(e);
    end else begin
      model_ovr = 1'b1;
    end
    @(negedge clk);
    trig = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    #1 reset = 1'b1;
    trig      = 1'b0;
    sb.delete();
    model_ph  = 0;
    next_free = 0;
    model_ovr = 1'b0;
    held      = 0;
    @(negedge clk);
    check("rst_sample_out", longint'(sample_out), 0);
    check("rst_sample_valid", longint'(sample_valid), 0);
    check("rst_busy", longint'(busy), 0);
    check("rst_trig_overrun", longint'(trig_overrun), 0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset) begin
      if (sb.size() > 0 && cyc > sb[0].due) begin
        e = sb.pop_front();
        check("valid_latency_expired", cyc, e.due);
      end
      if (sample_valid) begin
        if (sb.size() == 0) begin
          check("spurious_valid", longint'(sample_valid), 0);
        end else begin
          e = sb.pop_front();
          check("valid_latency", cyc, e.due);
          check("sample_out", longint'(int'($signed(sample_out))), e.val);
          check("busy_at_valid", longint'(busy), 0);
          held = e.val;
        end
      end else begin
        check("sample_hold", longint'(int'($signed(sample_out))), held);
      end
    end
  end

  initial begin
    reset = 1'b1;
    trig  = 1'b0;
    freq  = '0;
    wsel  = '0;
    amp   = '0;
    apply_reset();

    // Saw, +256 per sample from -32512.
    for (int i = 0; i < 5; i++) begin
      issue_trig(24'h010000, 2'd0, 16'hffff);
      check("busy_after_trig", longint'(busy), 1);
      idle(98);
    end

    // Triangle quarter-steps: 0, 32766, -1, -32768, 0.
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      issue_trig(24'h400000, 2'd2, 16'hffff);
      idle(30);
    end

    // Square at half gain, then from u = 0x8000.
    apply_reset();
    issue_trig(24'h010000, 2'd1, 16'h8000);
    idle(30);
    apply_reset();
    issue_trig(24'h800000, 2'd1, 16'h8000);
    idle(30);

    // Overrun: second trigger 5 clocks after the first is dropped.
    apply_reset();
    issue_trig(24'h010000, 2'd0, 16'hffff);
    check("ovr_clear_before", longint'(trig_overrun), longint'(model_ovr));
    idle(3);
    issue_trig(24'h010000, 2'd0, 16'hffff);
    check("ovr_set", longint'(trig_overrun), longint'(model_ovr));
    idle(40);
    check("ovr_sticky", longint'(trig_overrun), longint'(model_ovr));
    issue_trig(24'h010000, 2'd0, 16'hffff);
    idle(30);
    check("ovr_sticky_after_next", longint'(trig_overrun), longint'(model_ovr));

    // Inputs changed after acceptance must not disturb the sample in flight.
    apply_reset();
    issue_trig(24'h010000, 2'd0, 16'hffff);
    idle(2);
    freq = 24'h123456;
    wsel = 2'd2;
    amp  = 16'h4000;
    idle(40);
    issue_trig(24'h123456, 2'd2, 16'h4000);
    idle(30);

    // Reset mid-operation aborts the sample; phase restarts from zero.
    apply_reset();
    issue_trig(24'h0a0000, 2'd1, 16'hffff);
    idle(8);
    apply_reset();
    idle(40);
    issue_trig(24'h010000, 2'd0, 16'hffff);
    idle(30);

    // Randomized triggers, some landing while busy.
    apply_reset();
    for (int i = 0; i < 40; i++) begin
      issue_trig(24'($urandom), 2'($urandom_range(0, 3)), 16'($urandom));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(2, 15));
      else idle($urandom_range(20, 40));
    end

    for (int i = 0; i < 100 && sb.size() > 0; i++) @(negedge clk);
    check("drain_empty", longint'(sb.size()), 0);
    check("ovr_random", longint'(trig_overrun), longint'(model_ovr));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
